// File: rtl/dct_fxp_pkg.sv
// Shared constants for the DCT fixed-point datapath: default operand/result
// widths, the saturation bounds of the default result width, rounding and
// saturation mode selectors, and the saturation-counter geometry.
package dct_fxp_pkg;

  localparam int unsigned DCT_SAMPLE_W = 8;
  localparam int unsigned DCT_COEF_W   = 8;
  localparam int unsigned DCT_FRAC     = 6;
  localparam int unsigned DCT_OUT_W    = 16;

  // Clamp bounds for the default result width
  localparam logic signed [DCT_OUT_W-1:0] DCT_SAT_MAX = {1'b0, {(DCT_OUT_W-1){1'b1}}};
  localparam logic signed [DCT_OUT_W-1:0] DCT_SAT_MIN = {1'b1, {(DCT_OUT_W-1){1'b0}}};

  // Rounding modes
  localparam int unsigned ROUND_FLOOR   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  // Overflow handling modes
  localparam int unsigned SAT_WRAP  = 0;
  localparam int unsigned SAT_CLAMP = 1;

  // Saturation-event counter
  localparam int unsigned              SAT_CNT_W   = 16;
  localparam logic [SAT_CNT_W-1:0]     SAT_CNT_MAX = '1;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round / arithmetic shift / saturate of a signed product.
// Ports:
//   prod_i     - signed full-width product
//   result_c_o - rounded, shifted and clamped (or wrapped) result
//   sat_c_o    - high when result_c_o was clamped
module fxp_round_sat
  import dct_fxp_pkg::*;
#(
  parameter int unsigned IN_W      = DCT_SAMPLE_W + DCT_COEF_W,
  parameter int unsigned FRAC_BITS = DCT_FRAC,
  parameter int unsigned OUT_W     = DCT_OUT_W,
  parameter int unsigned ROUND_EN  = ROUND_HALF_UP,
  parameter int unsigned SAT_EN    = SAT_CLAMP
) (
  input  logic signed [IN_W-1:0]  prod_i,
  output logic signed [OUT_W-1:0] result_c_o,
  output logic                    sat_c_o
);

  // One guard bit so the rounding bias can never overflow
  localparam int unsigned EW = IN_W + 1;

  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0]    ext;
  logic signed [EW-1:0]    biased;
  logic signed [EW-1:0]    shifted;
  logic        [EW-OUT_W:0] top_bits;
  logic                    ovf;

  assign ext = {prod_i[IN_W-1], prod_i};

  // Half-LSB bias gives round-half-toward-+inf after the floor shift
  if (ROUND_EN != ROUND_FLOOR && FRAC_BITS > 0) begin : g_round
    localparam logic signed [EW-1:0] HALF = EW'(1) << (FRAC_BITS - 1);
    assign biased = ext + HALF;
  end else begin : g_floor
    assign biased = ext;
  end

  assign shifted  = biased >>> FRAC_BITS;

  // Result fits only if every bit above the output sign bit matches it
  assign top_bits = shifted[EW-1:OUT_W-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  assign sat_c_o    = (SAT_EN != SAT_WRAP) && ovf;
  assign result_c_o = sat_c_o ? (shifted[EW-1] ? MIN_V : MAX_V) : shifted[OUT_W-1:0];

endmodule

// File: rtl/signed_fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready handshake,
// selectable rounding, output saturation and a saturation-event counter.
// Ports:
//   i_clk, i_rst_n     - clock, asynchronous active-low reset
//   i_valid / o_ready  - operand handshake (o_ready is combinational from i_ready)
//   i_a, i_b           - signed operands
//   o_valid / i_ready  - result handshake
//   o_result, o_sat    - signed result and its clamp flag
//   i_sat_clr          - synchronous clear of o_sat_cnt
//   o_sat_cnt          - sticky-at-max count of delivered saturated results
module signed_fxp_mult_pipe
  import dct_fxp_pkg::*;
#(
  parameter int unsigned WIDTH_A   = DCT_SAMPLE_W,
  parameter int unsigned WIDTH_B   = DCT_COEF_W,
  parameter int unsigned FRAC_BITS = DCT_FRAC,
  parameter int unsigned OUT_WIDTH = DCT_OUT_W,
  parameter int unsigned ROUND_EN  = ROUND_HALF_UP,
  parameter int unsigned SAT_EN    = SAT_CLAMP,
  parameter int unsigned STAGES    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [WIDTH_A-1:0]   i_a,
  input  logic signed [WIDTH_B-1:0]   i_b,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [OUT_WIDTH-1:0] o_result,
  output logic                        o_sat,
  input  logic                        i_sat_clr,
  output logic [SAT_CNT_W-1:0]        o_sat_cnt
);

  localparam int unsigned PW = WIDTH_A + WIDTH_B;
  // Product stages ahead of the final result register
  localparam int unsigned NP = STAGES - 1;

  // Elaboration-time parameter checks
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("signed_fxp_mult_pipe: STAGES must be in 2..4");
  end
  if (FRAC_BITS > PW - 2) begin : g_bad_frac
    $error("signed_fxp_mult_pipe: FRAC_BITS must be in 0..WIDTH_A+WIDTH_B-2");
  end
  if (OUT_WIDTH < 2 || OUT_WIDTH > PW) begin : g_bad_out
    $error("signed_fxp_mult_pipe: OUT_WIDTH must be in 2..WIDTH_A+WIDTH_B");
  end

  logic                          advance;
  logic signed [PW-1:0]          prod_d;
  logic [NP-1:0][PW-1:0]         prod_q;
  logic [NP-1:0]                 vld_q;
  logic signed [OUT_WIDTH-1:0]   result_d;
  logic signed [OUT_WIDTH-1:0]   result_q;
  logic                          sat_d;
  logic                          sat_q;
  logic                          valid_q;
  logic                          sat_deliver;
  logic [SAT_CNT_W-1:0]          sat_cnt_d;
  logic [SAT_CNT_W-1:0]          sat_cnt_q;

  // Whole pipe moves as one; bubbles are kept as invalid slots
  assign advance = !valid_q || i_ready;
  assign o_ready = advance;

  // Exact full-width signed product
  assign prod_d = PW'(i_a) * PW'(i_b);

  fxp_round_sat #(
    .IN_W      (PW),
    .FRAC_BITS (FRAC_BITS),
    .OUT_W     (OUT_WIDTH),
    .ROUND_EN  (ROUND_EN),
    .SAT_EN    (SAT_EN)
  ) u_round_sat (
    .prod_i     ($signed(prod_q[NP-1])),
    .result_c_o (result_d),
    .sat_c_o    (sat_d)
  );

  // Pipeline registers; the concatenate-and-truncate shifts every stage by one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod_q   <= '0;
      vld_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else if (advance) begin
      prod_q   <= (NP*PW)'({prod_q, prod_d});
      vld_q    <= NP'({vld_q, i_valid});
      valid_q  <= vld_q[NP-1];
      result_q <= result_d;
      sat_q    <= sat_d && vld_q[NP-1];
    end
  end

  // Saturation counter: clear wins over hold, but a coincident saturated
  // delivery is still counted
  assign sat_deliver = valid_q && i_ready && sat_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr) begin
      sat_cnt_d = sat_deliver ? SAT_CNT_W'(1) : '0;
    end else if (sat_deliver && (sat_cnt_q != SAT_CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_result  = result_q;
  assign o_sat     = sat_q;
  assign o_sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_signed_fxp_mult_pipe.sv
// Directed bench for signed_fxp_mult_pipe. Four instances share the input
// side: default (Q1.6 -> 16b, round, clamp), floor rounding, 8-bit clamp
// and 8-bit wrap.
module tb_signed_fxp_mult_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid, i_ready, i_sat_clr;
  logic signed [7:0] i_a, i_b;

  logic rdy_d, vld_d, sat_d;
  logic signed [15:0] res_d;
  logic [15:0] cnt_d;
  logic rdy_f, vld_f, sat_f;
  logic signed [15:0] res_f;
  logic [15:0] cnt_f;
  logic rdy_s, vld_s, sat_s;
  logic signed [7:0] res_s;
  logic [15:0] cnt_s;
  logic rdy_w, vld_w, sat_w;
  logic signed [7:0] res_w;
  logic [15:0] cnt_w;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-computed vectors: operands, default, floor, 8b clamp (+flag), 8b wrap
  int va[10] = '{64, -64, 1, -1, 40, 127, -128, -128, 90, -100};
  int vb[10] = '{64,  64, 32, 32, 40, 127,  127, -128, 90,    3};
  int ed[10] = '{64, -64, 1,  0, 25, 252, -254,  256, 127,  -5};
  int ef[10] = '{64, -64, 0, -1, 25, 252, -254,  256, 126,  -5};
  int es[10] = '{64, -64, 1,  0, 25, 127, -128,  127, 127,  -5};
  bit ss[10] = '{0,   0,  0,  0,  0,   1,    1,    1,   0,   0};
  int ew[10] = '{64, -64, 1,  0, 25,  -4,    2,    0, 127,  -5};

  always #5 clk = ~clk;

  signed_fxp_mult_pipe dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy_d),
    .i_a(i_a), .i_b(i_b), .o_valid(vld_d), .i_ready(i_ready),
    .o_result(res_d), .o_sat(sat_d), .i_sat_clr(i_sat_clr), .o_sat_cnt(cnt_d));

  signed_fxp_mult_pipe #(.ROUND_EN(0)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy_f),
    .i_a(i_a), .i_b(i_b), .o_valid(vld_f), .i_ready(i_ready),
    .o_result(res_f), .o_sat(sat_f), .i_sat_clr(i_sat_clr), .o_sat_cnt(cnt_f));

  signed_fxp_mult_pipe #(.OUT_WIDTH(8)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy_s),
    .i_a(i_a), .i_b(i_b), .o_valid(vld_s), .i_ready(i_ready),
    .o_result(res_s), .o_sat(sat_s), .i_sat_clr(i_sat_clr), .o_sat_cnt(cnt_s));

  signed_fxp_mult_pipe #(.OUT_WIDTH(8), .SAT_EN(0)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy_w),
    .i_a(i_a), .i_b(i_b), .o_valid(vld_w), .i_ready(i_ready),
    .o_result(res_w), .o_sat(sat_w), .i_sat_clr(i_sat_clr), .o_sat_cnt(cnt_w));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for one cycle, then wait for its result slot
  task automatic drive_one(input int i);
    i_a = 8'(va[i]); i_b = 8'(vb[i]); i_valid = 1'b1; i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_sat_clr = 1'b0;
    i_a = '0; i_b = '0;
    #1 rst_n = 1'b0;
    step(); step();
    n_cmp++; if ({vld_d, vld_f, vld_s, vld_w} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_valid: got %b exp 0000", {vld_d, vld_f, vld_s, vld_w}); end
    n_cmp++; if (res_d !== 16'sd0 || res_s !== 8'sd0) begin n_bad++;
      $display("FAIL reset_result: got %0d/%0d exp 0/0", res_d, res_s); end
    n_cmp++; if ({sat_d, sat_s} !== 2'b00 || cnt_d !== 16'd0 || cnt_s !== 16'd0) begin n_bad++;
      $display("FAIL reset_sat: got sat %b%b cnt %0d/%0d exp 00 0/0", sat_d, sat_s, cnt_d, cnt_s); end
    n_cmp++; if (rdy_d !== 1'b1) begin n_bad++;
      $display("FAIL reset_ready: got %b exp 1", rdy_d); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (vld_d !== 1'b0) begin n_bad++;
      $display("FAIL reset_release_valid: got %b exp 0", vld_d); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 2; i++) begin
      i_a = 8'(va[i]); i_b = 8'(vb[i]); i_valid = 1'b1; i_ready = 1'b1;
      #1;
      n_cmp++; if (rdy_d !== 1'b1) begin n_bad++;
        $display("FAIL basic_ready[%0d]: got %b exp 1", i, rdy_d); end
      step();
      i_valid = 1'b0;
      n_cmp++; if (vld_d !== 1'b0) begin n_bad++;
        $display("FAIL basic_lat1[%0d]: got %b exp 0", i, vld_d); end
      step();
      n_cmp++; if (vld_d !== 1'b1) begin n_bad++;
        $display("FAIL basic_lat2[%0d]: got %b exp 1", i, vld_d); end
      n_cmp++; if (res_d !== 16'(ed[i]) || sat_d !== 1'b0) begin n_bad++;
        $display("FAIL basic_res_d[%0d]: got %0d sat %b exp %0d sat 0", i, res_d, sat_d, ed[i]); end
      n_cmp++; if (res_f !== 16'(ef[i]) || res_s !== 8'(es[i]) || res_w !== 8'(ew[i])) begin n_bad++;
        $display("FAIL basic_res_fsw[%0d]: got %0d/%0d/%0d exp %0d/%0d/%0d",
                 i, res_f, res_s, res_w, ef[i], es[i], ew[i]); end
      step();
      n_cmp++; if (vld_d !== 1'b0) begin n_bad++;
        $display("FAIL basic_drain[%0d]: got %b exp 0", i, vld_d); end
    end
  endtask

  task automatic test_rounding();
    for (int i = 2; i < 5; i++) begin
      drive_one(i);
      n_cmp++; if (vld_d !== 1'b1 || res_d !== 16'(ed[i])) begin n_bad++;
        $display("FAIL round_half_up[%0d]: got v%b %0d exp v1 %0d", i, vld_d, res_d, ed[i]); end
      n_cmp++; if (vld_f !== 1'b1 || res_f !== 16'(ef[i])) begin n_bad++;
        $display("FAIL round_floor[%0d]: got v%b %0d exp v1 %0d", i, vld_f, res_f, ef[i]); end
      step();
    end
  endtask

  task automatic test_saturation();
    for (int i = 5; i < 8; i++) begin
      drive_one(i);
      n_cmp++; if (res_s !== 8'(es[i]) || sat_s !== ss[i]) begin n_bad++;
        $display("FAIL sat_clamp[%0d]: got %0d sat %b exp %0d sat %b", i, res_s, sat_s, es[i], ss[i]); end
      n_cmp++; if (res_w !== 8'(ew[i]) || sat_w !== 1'b0) begin n_bad++;
        $display("FAIL sat_wrap[%0d]: got %0d sat %b exp %0d sat 0", i, res_w, sat_w, ew[i]); end
      n_cmp++; if (res_d !== 16'(ed[i]) || sat_d !== 1'b0) begin n_bad++;
        $display("FAIL sat_wide[%0d]: got %0d sat %b exp %0d sat 0", i, res_d, sat_d, ed[i]); end
      step();
    end
    n_cmp++; if (cnt_s !== 16'd3 || cnt_d !== 16'd0 || cnt_w !== 16'd0) begin n_bad++;
      $display("FAIL sat_count: got %0d/%0d/%0d exp 3/0/0", cnt_s, cnt_d, cnt_w); end
  endtask

  task automatic test_back_to_back();
    int q_d[$];
    int q_s[$];
    bit q_ss[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic signed [15:0] held;
    held = '0;
    while (got < 10 && cyc < 200) begin
      i_ready = (cyc % 3 == 0);
      i_valid = (sent < 10);
      if (sent < 10) begin
        i_a = 8'(va[sent]); i_b = 8'(vb[sent]);
      end
      #1;
      if (stalled) begin
        n_cmp++; if (vld_d !== 1'b1 || res_d !== held) begin n_bad++;
          $display("FAIL b2b_hold: got v%b %0d exp v1 %0d", vld_d, res_d, held); end
      end
      stalled = 1'b0;
      if (vld_d && !i_ready) begin
        n_cmp++; if (rdy_d !== 1'b0) begin n_bad++;
          $display("FAIL b2b_ready_stall: got %b exp 0", rdy_d); end
        stalled = 1'b1;
        held = res_d;
      end
      if (vld_d && i_ready) begin
        n_cmp++;
        if (q_d.size() == 0) begin n_bad++;
          $display("FAIL b2b_extra: got %0d exp none", res_d);
        end else if (res_d !== 16'(q_d[0]) || res_s !== 8'(q_s[0]) || sat_s !== q_ss[0]) begin n_bad++;
          $display("FAIL b2b_order[%0d]: got %0d/%0d sat %b exp %0d/%0d sat %b",
                   got, res_d, res_s, sat_s, q_d[0], q_s[0], q_ss[0]);
        end
        if (q_d.size() != 0) begin
          void'(q_d.pop_front()); void'(q_s.pop_front()); void'(q_ss.pop_front());
        end
        got++;
      end
      if (i_valid && rdy_d) begin
        q_d.push_back(ed[sent]); q_s.push_back(es[sent]); q_ss.push_back(ss[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_cmp++; if (got != 10 || sent != 10) begin n_bad++;
      $display("FAIL b2b_count: got %0d of %0d sent, exp 10 of 10", got, sent); end
    step(); step(); step();
    n_cmp++; if (vld_d !== 1'b0) begin n_bad++;
      $display("FAIL b2b_no_dup: got %b exp 0", vld_d); end
    n_cmp++; if (cnt_s !== 16'd6) begin n_bad++;
      $display("FAIL b2b_sat_count: got %0d exp 6", cnt_s); end
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b1; i_valid = 1'b1;
    i_a = 8'(va[5]); i_b = 8'(vb[5]);
    step();
    i_a = 8'(va[6]); i_b = 8'(vb[6]);
    step();
    i_valid = 1'b0; i_ready = 1'b0;
    #2;
    n_cmp++; if (vld_s !== 1'b1 || res_s !== 8'(es[5])) begin n_bad++;
      $display("FAIL rst_mid_pre: got v%b %0d exp v1 %0d", vld_s, res_s, es[5]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (vld_d !== 1'b0 || vld_s !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid_valid: got %b%b exp 00", vld_d, vld_s); end
    n_cmp++; if (cnt_s !== 16'd0 || res_s !== 8'sd0 || sat_s !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid_state: got cnt %0d res %0d sat %b exp 0 0 0", cnt_s, res_s, sat_s); end
    #2 rst_n = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (vld_d !== 1'b0 || vld_s !== 1'b0) begin n_bad++;
        $display("FAIL rst_mid_stale[%0d]: got %b%b exp 00", k, vld_d, vld_s); end
    end
  endtask

  task automatic test_counter_edges();
    i_a = 8'sd127; i_b = 8'sd127; i_valid = 1'b1; i_ready = 1'b1;
    step(); step(); step();
    n_cmp++; if (cnt_s !== 16'd1) begin n_bad++;
      $display("FAIL cnt_first: got %0d exp 1", cnt_s); end
    repeat (65540) step();
    n_cmp++; if (cnt_s !== 16'hFFFF) begin n_bad++;
      $display("FAIL cnt_sticky: got %0d exp 65535", cnt_s); end
    n_cmp++; if (cnt_d !== 16'd0) begin n_bad++;
      $display("FAIL cnt_no_sat: got %0d exp 0", cnt_d); end
    i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;
    n_cmp++; if (cnt_s !== 16'd1) begin n_bad++;
      $display("FAIL cnt_clr_with_sat: got %0d exp 1", cnt_s); end
    step();
    n_cmp++; if (cnt_s !== 16'd2) begin n_bad++;
      $display("FAIL cnt_resume: got %0d exp 2", cnt_s); end
    i_valid = 1'b0;
    step(); step(); step();
    i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;
    n_cmp++; if (cnt_s !== 16'd0) begin n_bad++;
      $display("FAIL cnt_clr_plain: got %0d exp 0", cnt_s); end
    step();
    n_cmp++; if (cnt_s !== 16'd0 || vld_s !== 1'b0) begin n_bad++;
      $display("FAIL cnt_idle: got cnt %0d v%b exp 0 v0", cnt_s, vld_s); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    test_counter_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/signed_fxp_mult_pipe.md
Name: signed_fxp_mult_pipe

Overview:
- Parametrised, pipelined signed fixed-point multiplier with valid/ready handshake, selectable rounding, output saturation and a saturation-event counter.
- Replaces the fixed 8x8, truncate-only combinational multiplier in the DCT datapath.
- Sits between the coefficient/sample fetch logic and the DCT accumulators.

Parameters:
- WIDTH_A, 8: signed width of operand A (sample).
- WIDTH_B, 8: signed width of operand B (coefficient).
- FRAC_BITS, 6: right shift applied to the full product; range 0..WIDTH_A+WIDTH_B-2.
- OUT_WIDTH, 16: signed result width; range 2..WIDTH_A+WIDTH_B.
- ROUND_EN, 1: 1 = round half toward +inf before the shift; 0 = floor (arithmetic shift).
- SAT_EN, 1: 1 = clamp to OUT_WIDTH signed range; 0 = wrap (keep low OUT_WIDTH bits).
- STAGES, 2: pipeline depth, 2..4. Stage 1 registers the product; the last stage registers the rounded, saturated result.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_valid, in, 1: input operands valid.
- o_ready, out, 1: block accepts operands this cycle.
- i_a, in, WIDTH_A: signed operand A.
- i_b, in, WIDTH_B: signed operand B.
- o_valid, out, 1: result valid.
- i_ready, in, 1: downstream accepts the result.
- o_result, out, OUT_WIDTH: signed result.
- o_sat, out, 1: the result on o_result was clamped (qualified by o_valid).
- i_sat_clr, in, 1: synchronous clear of o_sat_cnt.
- o_sat_cnt, out, 16: number of saturated results delivered; sticks at 0xFFFF.

Behaviour:
- Reset: asynchronous on i_rst_n low.
  - All stage valid bits, o_valid, o_result, o_sat and o_sat_cnt go to 0.
  - Reset mid-operation discards all in-flight data.
- Advance condition: advance = !o_valid || i_ready.
  - All stages shift together when advance = 1; all hold when advance = 0.
  - o_ready = advance. This is a combinational path from i_ready to o_ready and is accepted.
- Transfer rules:
  - An input is taken when i_valid && o_ready.
  - An output is delivered when o_valid && i_ready.
  - Data and flags hold stable while o_valid && !i_ready.
- Latency: exactly STAGES cycles from acceptance to o_valid when not stalled.
  - Throughput: 1 result per cycle.
  - Bubbles (i_valid = 0) travel through the pipe as invalid slots and are not collapsed.
- Arithmetic:
  - P = signed(i_a) * signed(i_b), full width WIDTH_A+WIDTH_B, exact. Includes the most-negative x most-negative case.
  - ROUND_EN = 1 and FRAC_BITS > 0: R = (P + 2^(FRAC_BITS-1)) >>> FRAC_BITS, evaluated with one guard bit so there is no overflow.
  - Otherwise: R = P >>> FRAC_BITS.
  - SAT_EN = 1:
    - R > 2^(OUT_WIDTH-1)-1 gives the maximum value; R < -2^(OUT_WIDTH-1) gives the minimum value.
    - o_sat = 1 on clamp, else 0.
  - SAT_EN = 0: o_result = R[OUT_WIDTH-1:0] and o_sat is always 0.
- Saturation counter:
  - Increments by 1 on each delivered result with o_sat = 1; sticks at 0xFFFF.
  - If i_sat_clr and a saturated delivery happen in the same cycle, the counter loads 1.
- Illegal parameter combinations are rejected at elaboration: STAGES outside 2..4, FRAC_BITS too large, OUT_WIDTH out of range.

Decomposition:
- Shared package dct_fxp_pkg holds:
  - the default widths (DCT_SAMPLE_W = 8, DCT_COEF_W = 8, DCT_FRAC = 6);
  - the localparams for the maximum and minimum saturation bounds;
  - the ROUND_* mode constants.
- One combinational sub-module, fxp_round_sat, performs round, shift and saturate and drives the sat flag. It is reused by the DCT accumulator output stage.
- Pipeline registers and the handshake stay in the top module.

Test Plan (defaults unless stated):
- Basic multiply:
  - 64*64 (1.0*1.0 in Q1.6) -> o_result = 64, o_sat = 0, o_valid exactly 2 cycles after acceptance.
  - -64*64 -> -64.
- Rounding:
  - 1*32 -> 1 (half rounds up); -1*32 -> 0; 40*40 -> 25.
  - With ROUND_EN = 0: 1*32 -> 0 and -1*32 -> -1.
- Saturation with OUT_WIDTH = 8:
  - 127*127 -> 127, o_sat = 1.
  - -128*127 -> -128, o_sat = 1.
  - -128*-128 -> 127, o_sat = 1.
  - After these three deliveries o_sat_cnt = 3.
- Backpressure:
  - Stream 10 back-to-back operand pairs with i_ready toggling 1,0,0,1...
  - Required: no loss or duplication, results in order, o_result held stable while stalled, o_ready = 0 whenever o_valid && !i_ready.
- Reset mid-stream:
  - Assert i_rst_n = 0 asynchronously with 2 results in flight.
  - Required: o_valid falls immediately, o_sat_cnt = 0, and no stale result appears after release.
- Counter edges:
  - Force 65540 saturated deliveries -> o_sat_cnt sticks at 0xFFFF.
  - i_sat_clr together with a saturated delivery -> o_sat_cnt = 1.
